// File: rtl/hsv_core_pkg.sv
// Shared issue/commit types: register masks, instruction tokens and issue FSM states.
// Optional build macro used by this slice: HSV_SCOREBOARD_BYPASS_EN.
package hsv_core_pkg;

   localparam int HSV_TOKEN_WIDTH  = 8;
   localparam int HSV_MAX_INFLIGHT = 8;

   typedef logic [31:0]                reg_mask;
   typedef logic [HSV_TOKEN_WIDTH-1:0] insn_token;

   typedef enum logic {
      ISSUE_RUN,
      ISSUE_FLUSH
   } issue_state_t;

   // x0 never carries a dependency.
   function automatic reg_mask strip_x0(reg_mask m);
      return {m[31:1], 1'b0};
   endfunction

endpackage

// File: rtl/hsv_core_issue_hazard.sv
// RAW/WAW hazard check of an incoming instruction against outstanding writes.
// HSV_SCOREBOARD_BYPASS_EN lets a same-cycle commit release clear the hazard.
module hsv_core_issue_hazard
   import hsv_core_pkg::*;
(
   input  logic [31:0] rs_mask,
   input  logic [31:0] rd_mask,
   input  logic [31:0] pending_mask,
   input  logic [31:0] commit_mask,
   output logic        hazard
);

   reg_mask eff_pending;

`ifdef HSV_SCOREBOARD_BYPASS_EN
   assign eff_pending = pending_mask & ~commit_mask;
`else
   // Releases take effect a cycle later; keeps commit off the issue path.
   logic unused_commit;
   assign unused_commit = ^commit_mask;
   assign eff_pending   = pending_mask;
`endif

   assign hazard = |(strip_x0(rs_mask | rd_mask) & eff_pending);

endmodule

// File: rtl/hsv_core_issue_scoreboard.sv
// Issue scoreboard: stamps in-order tokens, blocks on pending writes, follows commit flush.
// Build option: HSV_SCOREBOARD_BYPASS_EN (see hsv_core_issue_hazard).
module hsv_core_issue_scoreboard
   import hsv_core_pkg::*;
#(
   parameter int MAX_INFLIGHT = HSV_MAX_INFLIGHT,
   parameter int TOKEN_WIDTH  = HSV_TOKEN_WIDTH
) (
   input  logic                   clk_core,
   input  logic                   rst_core,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_rs_mask,
   input  logic [31:0]            in_rd_mask,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [TOKEN_WIDTH-1:0] out_token,
   output logic [31:0]            out_rd_mask,
   input  logic                   commit_valid,
   input  logic [31:0]            commit_mask,
   input  logic                   flush_req,
   output logic                   flush_ack,
   output logic [31:0]            pending_mask
);

   localparam int            IW       = $clog2(MAX_INFLIGHT + 1);
   localparam logic [IW-1:0] INFL_MAX = IW'(MAX_INFLIGHT);

   issue_state_t           state;
   issue_state_t           state_nxt;
   logic [TOKEN_WIDTH-1:0] token;
   reg_mask                pending;
   logic [IW-1:0]          inflight;
   logic                   hazard;
   logic                   running;
   logic                   flushing;
   logic                   accept;

   hsv_core_issue_hazard u_hazard (
      .rs_mask      (in_rs_mask),
      .rd_mask      (in_rd_mask),
      .pending_mask (pending),
      .commit_mask  (commit_mask),
      .hazard       (hazard)
   );

   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         state <= ISSUE_FLUSH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ISSUE_RUN:   if (flush_req) state_nxt = ISSUE_FLUSH;
         ISSUE_FLUSH: if (!flush_req && flush_ack) state_nxt = ISSUE_RUN;
      endcase
   end

   always_comb begin
      running  = (state == ISSUE_RUN);
      in_ready = running && !hazard
              && (inflight < INFL_MAX)
              && (!out_valid || out_ready);
   end

   assign accept       = in_valid & in_ready;
   // A flush request wins over accept and commit in the same cycle.
   assign flushing     = flush_req | ~running;
   assign pending_mask = pending;

   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         flush_ack <= 1'b1;
      end else begin
         flush_ack <= flush_req;
      end
   end

   always_ff @(posedge clk_core) begin
      if (rst_core || flushing) begin
         token     <= '0;
         pending   <= '0;
         inflight  <= '0;
         out_valid <= 1'b0;
      end else begin
         // A new set of a bit wins over its release in the same cycle.
         pending <= strip_x0((pending & ~commit_mask)
                           | (accept ? in_rd_mask : '0));
         if (accept) begin
            token <= token + TOKEN_WIDTH'(1);
         end
         if (accept && !commit_valid) begin
            inflight <= inflight + IW'(1);
         end else if (!accept && commit_valid && inflight != '0) begin
            inflight <= inflight - IW'(1);
         end
         if (accept) begin
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         out_token   <= '0;
         out_rd_mask <= '0;
      end else if (accept && !flush_req) begin
         out_token   <= token;
         out_rd_mask <= in_rd_mask;
      end
   end

   a_no_commit_underflow : assert property (
      @(posedge clk_core) disable iff (rst_core)
      (running && !flush_req && commit_valid) |-> (inflight != '0)
   );

endmodule

// File: tb/tb_hsv_core_issue_scoreboard.sv
// Directed bench for the issue scoreboard; issued tokens checked through a scoreboard queue.
module tb_hsv_core_issue_scoreboard;

   logic        clk_core;
   logic        rst_core;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_rs_mask;
   logic [31:0] in_rd_mask;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_token;
   logic [31:0] out_rd_mask;
   logic        commit_valid;
   logic [31:0] commit_mask;
   logic        flush_req;
   logic        flush_ack;
   logic [31:0] pending_mask;

   typedef struct packed {
      logic [7:0]  tok;
      logic [31:0] rd;
   } exp_t;

   exp_t       exp_q[$];
   int         vectors     = 0;
   int         miscompares = 0;
   logic [7:0] nt;
   int         w;

`ifdef HSV_SCOREBOARD_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   hsv_core_issue_scoreboard #(
      .MAX_INFLIGHT (8),
      .TOKEN_WIDTH  (8)
   ) dut (
      .clk_core     (clk_core),
      .rst_core     (rst_core),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_rs_mask   (in_rs_mask),
      .in_rd_mask   (in_rd_mask),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_token    (out_token),
      .out_rd_mask  (out_rd_mask),
      .commit_valid (commit_valid),
      .commit_mask  (commit_mask),
      .flush_req    (flush_req),
      .flush_ack    (flush_ack),
      .pending_mask (pending_mask)
   );

   initial clk_core = 1'b0;
   always #5 clk_core = ~clk_core;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   task automatic cyc();
      @(negedge clk_core);
      #1;
   endtask

   task automatic issue(input logic [31:0] rs, input logic [31:0] rd,
                        input logic [7:0] tok, input int max_wait,
                        output int waited);
      waited     = 0;
      in_valid   = 1'b1;
      in_rs_mask = rs;
      in_rd_mask = rd;
      #1;
      while (!in_ready && waited < max_wait) begin
         cyc();
         waited++;
      end
      if (in_ready) begin
         exp_q.push_back('{tok: tok, rd: rd});
      end else begin
         chk("issue_timeout", 32'(in_ready), 32'd1);
      end
      cyc();
      in_valid   = 1'b0;
      in_rs_mask = '0;
      in_rd_mask = '0;
   endtask

   task automatic commit(input logic [31:0] m);
      commit_valid = 1'b1;
      commit_mask  = m;
      cyc();
      commit_valid = 1'b0;
      commit_mask  = '0;
   endtask

   // Monitor: pops an expectation on every out handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_core);
         #3;
         if (!rst_core && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 32'(out_token), 32'hffff_ffff);
            end else begin
               e = exp_q.pop_front();
               chk("out_token", 32'(out_token), 32'(e.tok));
               chk("out_rd_mask", out_rd_mask, e.rd);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_core     = 1'b1;
      in_valid     = 1'b0;
      in_rs_mask   = '0;
      in_rd_mask   = '0;
      out_ready    = 1'b1;
      commit_valid = 1'b0;
      commit_mask  = '0;
      flush_req    = 1'b0;
      repeat (3) cyc();
      chk("rst_flush_ack", 32'(flush_ack), 32'd1);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_token", 32'(out_token), 32'd0);
      chk("rst_out_rd", out_rd_mask, 32'd0);
      chk("rst_pending", pending_mask, 32'd0);
      rst_core = 1'b0;
      #1;
      chk("first_cycle_flush", 32'(in_ready), 32'd0);
      cyc();
      chk("run_in_ready", 32'(in_ready), 32'd1);
      chk("run_flush_ack", 32'(flush_ack), 32'd0);

      // Back-to-back independent issue
      issue(32'h0, 32'h2, 8'd0, 4, w);
      chk("b2b_wait0", 32'(w), 32'd0);
      issue(32'h0, 32'h4, 8'd1, 4, w);
      chk("b2b_wait1", 32'(w), 32'd0);
      issue(32'h0, 32'h8, 8'd2, 4, w);
      chk("b2b_wait2", 32'(w), 32'd0);
      chk("b2b_pending", pending_mask, 32'h0000_000e);
      commit(32'h2);
      commit(32'h4);
      commit(32'h8);
      chk("b2b_released", pending_mask, 32'd0);

      // RAW on x5
      issue(32'h0, 32'h20, 8'd3, 4, w);
      chk("raw_pending", pending_mask, 32'h20);
      in_valid   = 1'b1;
      in_rs_mask = 32'h20;
      in_rd_mask = 32'h0;
      #1;
      chk("raw_stall0", 32'(in_ready), 32'd0);
      cyc();
      chk("raw_stall1", 32'(in_ready), 32'd0);
      commit_valid = 1'b1;
      commit_mask  = 32'h20;
      #1;
      chk("raw_commit_cycle", 32'(in_ready), 32'(BYP));
      if (in_ready) exp_q.push_back('{tok: 8'd4, rd: 32'h0});
      cyc();
      commit_valid = 1'b0;
      commit_mask  = '0;
      if (!BYP) begin
         #1;
         chk("raw_next_cycle", 32'(in_ready), 32'd1);
         if (in_ready) exp_q.push_back('{tok: 8'd4, rd: 32'h0});
         cyc();
      end
      in_valid   = 1'b0;
      in_rs_mask = '0;
      commit(32'h0);
      chk("raw_released", pending_mask, 32'd0);
      nt = 8'd5;

      // Inflight limit
      for (int i = 0; i < 8; i++) begin
         issue(32'h0, 32'h0, nt, 4, w);
         nt++;
      end
      in_valid = 1'b1;
      #1;
      chk("full_stall0", 32'(in_ready), 32'd0);
      cyc();
      chk("full_stall1", 32'(in_ready), 32'd0);
      commit_valid = 1'b1;
      #1;
      chk("full_commit_cycle", 32'(in_ready), 32'd0);
      cyc();
      commit_valid = 1'b0;
      #1;
      chk("full_after_commit", 32'(in_ready), 32'd1);
      if (in_ready) exp_q.push_back('{tok: nt, rd: 32'h0});
      cyc();
      in_valid = 1'b0;
      nt++;
      repeat (8) commit(32'h0);

      // Output backpressure
      issue(32'h0, 32'h40, nt, 4, w);
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      in_rd_mask = 32'h80;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_token", 32'(out_token), 32'(nt));
         chk("bp_out_rd", out_rd_mask, 32'h40);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         cyc();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release", 32'(in_ready), 32'd1);
      if (in_ready) exp_q.push_back('{tok: nt + 8'd1, rd: 32'h80});
      cyc();
      in_valid   = 1'b0;
      in_rd_mask = '0;
      nt = nt + 8'd2;
      commit(32'h40);
      commit(32'h80);

      // x0 never creates a dependency
      issue(32'h1, 32'h1, nt, 3, w);
      nt++;
      chk("x0_pending", pending_mask, 32'd0);
      issue(32'h1, 32'h1, nt, 3, w);
      nt++;
      chk("x0_no_stall", 32'(w), 32'd0);
      commit(32'h1);
      commit(32'h1);

      // Token wrap
      while (nt != 8'd255) begin
         issue(32'h0, 32'h0, nt, 4, w);
         nt++;
         commit(32'h0);
      end
      issue(32'h0, 32'h2, 8'd255, 4, w);
      issue(32'h0, 32'h4, 8'd0, 4, w);
      chk("wrap_b2b", 32'(w), 32'd0);
      commit(32'h2);
      commit(32'h4);
      nt = 8'd1;

      // Mid-stream flush
      issue(32'h0, 32'h20, nt, 4, w);
      issue(32'h0, 32'h40, nt + 8'd1, 4, w);
      issue(32'h0, 32'h0, nt + 8'd2, 4, w);
      chk("fl_pending_before", pending_mask, 32'h60);
      out_ready = 1'b0;
      flush_req = 1'b1;
      void'(exp_q.pop_back());
      cyc();
      chk("fl_out_valid", 32'(out_valid), 32'd0);
      chk("fl_pending", pending_mask, 32'd0);
      chk("fl_ack", 32'(flush_ack), 32'd1);
      chk("fl_in_ready", 32'(in_ready), 32'd0);
      cyc();
      flush_req = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("fl_still_flush", 32'(in_ready), 32'd0);
      cyc();
      chk("fl_run_in_ready", 32'(in_ready), 32'd1);
      chk("fl_run_ack", 32'(flush_ack), 32'd0);
      issue(32'h0, 32'h20, 8'd0, 4, w);
      commit(32'h20);
      repeat (2) cyc();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
